// File: rtl/masked_pkg.sv
// Shared types and helpers for the two-share Boolean-masked gadgets.
package masked_pkg;

    localparam int unsigned SHARES = 2;

    // One bit split into two Boolean shares; bit j holds share j.
    typedef logic [SHARES-1:0] sh_bit_t;

    function automatic int unsigned lat(input int unsigned width);
        return width + 2;
    endfunction

endpackage

// File: rtl/dom_and_2sh.sv
// Two-share DOM-indep AND gadget: four registered terms, cross terms masked by r.
module dom_and_2sh (
    input  logic clk,
    input  logic rst,
    input  logic x0,
    input  logic x1,
    input  logic y0,
    input  logic y1,
    input  logic r,
    output logic z0,
    output logic z1
);

    logic q00;
    logic q01;
    logic q11;
    logic q10;

    // Cross-domain products only leave the gate after masking with r.
    always_ff @(posedge clk) begin
        if (rst) begin
            q00 <= 1'b0;
            q01 <= 1'b0;
            q11 <= 1'b0;
            q10 <= 1'b0;
        end else begin
            q00 <= x0 & y0;
            q01 <= (x0 & y1) ^ r;
            q11 <= x1 & y1;
            q10 <= (x1 & y0) ^ r;
        end
    end

    assign z0 = q00 ^ q01;
    assign z1 = q11 ^ q10;

endmodule

// File: rtl/masked_adder_pipe.sv
// Fully pipelined two-share masked ripple-carry adder; one carry stage per bit,
// one result per cycle, latency WIDTH+2.
module masked_adder_pipe
    import masked_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    input  logic [WIDTH-1:0]   i_a0,
    input  logic [WIDTH-1:0]   i_a1,
    input  logic [WIDTH-1:0]   i_b0,
    input  logic [WIDTH-1:0]   i_b1,
    input  logic [2*WIDTH-1:0] i_rnd,
    output logic               o_valid,
    output logic [WIDTH-1:0]   o_sum0,
    output logic [WIDTH-1:0]   o_sum1,
    output logic               o_cout0,
    output logic               o_cout1
);

    localparam int unsigned LAT = lat(WIDTH);

    logic [LAT-1:0]   vld_sr;
    sh_bit_t          carry [WIDTH+1];
    logic [WIDTH-1:0] sum0_c;
    logic [WIDTH-1:0] sum1_c;

    assign carry[0] = '0;

    // Valid tracking only; data registers run freely.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr <= '0;
        end else begin
            vld_sr <= {vld_sr[LAT-2:0], i_valid};
        end
    end

    assign o_valid = vld_sr[LAT-1];

    for (genvar s = 0; s < WIDTH; s++) begin : g_stage
        // Operand bit s waits s cycles past the input register; p_s and c_s
        // then wait until the common output register.
        localparam int unsigned AD = s + 1;
        localparam int unsigned PD = WIDTH - s;

        sh_bit_t a_dl [AD];
        sh_bit_t a_nx [AD];
        sh_bit_t b_dl [AD];
        sh_bit_t b_nx [AD];
        sh_bit_t p_dl [PD];
        sh_bit_t p_nx [PD];
        sh_bit_t c_dl [PD];
        sh_bit_t c_nx [PD];
        sh_bit_t p_c;
        sh_bit_t g_c;
        sh_bit_t t_c;

        assign a_nx[0] = {i_a1[s], i_a0[s]};
        assign b_nx[0] = {i_b1[s], i_b0[s]};
        for (genvar k = 1; k < AD; k++) begin : g_ad
            assign a_nx[k] = a_dl[k-1];
            assign b_nx[k] = b_dl[k-1];
        end

        assign p_c     = a_dl[s] ^ b_dl[s];
        assign p_nx[0] = p_c;
        assign c_nx[0] = carry[s];
        for (genvar k = 1; k < PD; k++) begin : g_pd
            assign p_nx[k] = p_dl[k-1];
            assign c_nx[k] = c_dl[k-1];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                a_dl <= '{default: '0};
                b_dl <= '{default: '0};
                p_dl <= '{default: '0};
                c_dl <= '{default: '0};
            end else begin
                a_dl <= a_nx;
                b_dl <= b_nx;
                p_dl <= p_nx;
                c_dl <= c_nx;
            end
        end

        dom_and_2sh u_gen (
            .clk (clk),
            .rst (rst),
            .x0  (a_dl[s][0]),
            .x1  (a_dl[s][1]),
            .y0  (b_dl[s][0]),
            .y1  (b_dl[s][1]),
            .r   (i_rnd[2*s]),
            .z0  (g_c[0]),
            .z1  (g_c[1])
        );

        // Stage 0 still runs this gate on zero carry shares to keep stages uniform.
        dom_and_2sh u_prop (
            .clk (clk),
            .rst (rst),
            .x0  (p_c[0]),
            .x1  (p_c[1]),
            .y0  (carry[s][0]),
            .y1  (carry[s][1]),
            .r   (i_rnd[2*s+1]),
            .z0  (t_c[0]),
            .z1  (t_c[1])
        );

        assign carry[s+1] = g_c ^ t_c;
        assign sum0_c[s]  = p_dl[PD-1][0] ^ c_dl[PD-1][0];
        assign sum1_c[s]  = p_dl[PD-1][1] ^ c_dl[PD-1][1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_sum0  <= '0;
            o_sum1  <= '0;
            o_cout0 <= 1'b0;
            o_cout1 <= 1'b0;
        end else begin
            o_sum0  <= sum0_c;
            o_sum1  <= sum1_c;
            o_cout0 <= carry[WIDTH][0];
            o_cout1 <= carry[WIDTH][1];
        end
    end

endmodule

// File: tb/tb_masked_adder_pipe.sv
// Directed bench for masked_adder_pipe: a WIDTH=4 and a WIDTH=1 build side by side.
module tb_masked_adder_pipe;
    import masked_pkg::*;

    localparam int unsigned W4   = 4;
    localparam int unsigned W1   = 1;
    localparam int unsigned LAT4 = lat(W4);
    localparam int unsigned LAT1 = lat(W1);

    typedef struct {
        logic       v;
        logic [3:0] sum;
        logic       cout;
        int         tag;
    } exp_t;

    typedef struct {
        logic [3:0] a, b, sum;
        logic       cout;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       v4, v1;
    logic [3:0] a40, a41, b40, b41;
    logic [7:0] rnd4;
    logic       a10, a11, b10, b11;
    logic [1:0] rnd1;
    logic       ov4, c40, c41, ov1, c10, c11;
    logic [3:0] s40, s41;
    logic       s10, s11;

    exp_t       q4[$];
    exp_t       q1[$];
    exp_t       cur4, cur1;
    vec_t       vt [9];
    logic [3:0] sh0 [8];
    int         n_vec;
    int         n_err;

    masked_adder_pipe #(.WIDTH(W4)) dut4 (
        .clk(clk), .rst(rst), .i_valid(v4),
        .i_a0(a40), .i_a1(a41), .i_b0(b40), .i_b1(b41), .i_rnd(rnd4),
        .o_valid(ov4), .o_sum0(s40), .o_sum1(s41), .o_cout0(c40), .o_cout1(c41)
    );

    masked_adder_pipe #(.WIDTH(W1)) dut1 (
        .clk(clk), .rst(rst), .i_valid(v1),
        .i_a0(a10), .i_a1(a11), .i_b0(b10), .i_b1(b11), .i_rnd(rnd1),
        .o_valid(ov1), .o_sum0(s10), .o_sum1(s11), .o_cout0(c10), .o_cout1(c11)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic idle4();
        a40 = 4'($urandom); a41 = 4'($urandom);
        b40 = 4'($urandom); b41 = 4'($urandom);
        v4  = 1'b0;
        cur4 = '{v: 1'b0, sum: 4'd0, cout: 1'b0, tag: -1};
    endtask

    task automatic idle1();
        a10 = 1'($urandom); a11 = 1'($urandom);
        b10 = 1'($urandom); b11 = 1'($urandom);
        v1  = 1'b0;
        cur1 = '{v: 1'b0, sum: 4'd0, cout: 1'b0, tag: -1};
    endtask

    task automatic set4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] es, input logic ec, input int tag);
        logic [3:0] m;
        m = 4'($urandom); a40 = m; a41 = a ^ m;
        m = 4'($urandom); b40 = m; b41 = b ^ m;
        v4 = 1'b1;
        cur4 = '{v: 1'b1, sum: es, cout: ec, tag: tag};
    endtask

    task automatic set1(input logic a, input logic b, input logic es, input logic ec);
        logic m;
        m = 1'($urandom); a10 = m; a11 = a ^ m;
        m = 1'($urandom); b10 = m; b11 = b ^ m;
        v1 = 1'b1;
        cur1 = '{v: 1'b1, sum: {3'd0, es}, cout: ec, tag: -1};
    endtask

    task automatic check4(input logic r_now);
        exp_t e;
        if (r_now) begin
            chk("rst_clear4", 16'({ov4, c40, c41, s40, s41}), 16'd0);
        end else begin
            e = '{v: 1'b0, sum: 4'd0, cout: 1'b0, tag: -1};
            if (q4.size() == int'(LAT4)) e = q4.pop_front();
            chk("valid4", 16'(ov4), 16'(e.v));
            if (e.v) begin
                chk("sum4", 16'({c40 ^ c41, s40 ^ s41}), 16'({e.cout, e.sum}));
                if (e.tag >= 0 && e.tag < 8) sh0[e.tag] = s40;
            end
        end
    endtask

    task automatic check1(input logic r_now);
        exp_t e;
        if (r_now) begin
            chk("rst_clear1", 16'({ov1, c10, c11, s10, s11}), 16'd0);
        end else begin
            e = '{v: 1'b0, sum: 4'd0, cout: 1'b0, tag: -1};
            if (q1.size() == int'(LAT1)) e = q1.pop_front();
            chk("valid1", 16'(ov1), 16'(e.v));
            if (e.v) chk("sum1", 16'({c10 ^ c11, s10 ^ s11}), 16'({e.cout, e.sum[0]}));
        end
    endtask

    // One clock: fresh randomness, model update, edge, compare, then idle inputs.
    task automatic cycle();
        logic r_now;
        r_now = rst;
        rnd4 = 8'($urandom);
        rnd1 = 2'($urandom);
        if (r_now) begin
            q4.delete();
            q1.delete();
        end else begin
            q4.push_back(cur4);
            q1.push_back(cur1);
        end
        @(posedge clk);
        #1;
        check4(r_now);
        check1(r_now);
        idle4();
        idle1();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int       cnt;
        logic [4:0] gold;

        n_vec = 0;
        n_err = 0;
        vt[0] = '{a: 4'd3,  b: 4'd5,  sum: 4'd8,  cout: 1'b0};
        vt[1] = '{a: 4'd15, b: 4'd1,  sum: 4'd0,  cout: 1'b1};
        vt[2] = '{a: 4'd15, b: 4'd15, sum: 4'd14, cout: 1'b1};
        vt[3] = '{a: 4'd9,  b: 4'd6,  sum: 4'd15, cout: 1'b0};
        vt[4] = '{a: 4'd0,  b: 4'd0,  sum: 4'd0,  cout: 1'b0};
        vt[5] = '{a: 4'd8,  b: 4'd8,  sum: 4'd0,  cout: 1'b1};
        vt[6] = '{a: 4'd7,  b: 4'd9,  sum: 4'd0,  cout: 1'b1};
        vt[7] = '{a: 4'd10, b: 4'd3,  sum: 4'd13, cout: 1'b0};
        vt[8] = '{a: 4'd12, b: 4'd7,  sum: 4'd3,  cout: 1'b1};
        for (int k = 0; k < 8; k++) sh0[k] = 4'd0;

        idle4();
        idle1();
        rnd4 = 8'd0;
        rnd1 = 2'd0;

        // Reset held two cycles with valid traffic, then idle.
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set4(4'($urandom), 4'($urandom), 4'd0, 1'b0, -1);
            set1(1'($urandom), 1'($urandom), 1'b0, 1'b0);
            cycle();
        end
        rst = 1'b0;
        drain(int'(LAT4) + 1);

        // Isolated directed vectors.
        for (int i = 0; i < 9; i++) begin
            set4(vt[i].a, vt[i].b, vt[i].sum, vt[i].cout, -1);
            cycle();
            drain(int'(LAT4));
        end

        // Back-to-back exhaustive sweep.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                gold = 5'(a) + 5'(b);
                set4(4'(a), 4'(b), gold[3:0], gold[4], -1);
                cycle();
            end
        end
        drain(int'(LAT4));

        // Same operands, fresh masks each time.
        for (int k = 0; k < 8; k++) begin
            set4(4'd9, 4'd6, 4'd15, 1'b0, k);
            cycle();
        end
        drain(int'(LAT4));
        cnt = 0;
        for (int k = 1; k < 8; k++) if (sh0[k] != sh0[0]) cnt++;
        chk("mask_shares_vary", 16'(cnt != 0), 16'd1);

        // Reset with three ops in flight; first op after release must survive.
        for (int i = 0; i < 3; i++) begin
            set4(vt[i].a, vt[i].b, vt[i].sum, vt[i].cout, -1);
            set1(1'b1, 1'b1, 1'b0, 1'b1);
            cycle();
        end
        rst = 1'b1;
        set4(4'd1, 4'd1, 4'd2, 1'b0, -1);
        cycle();
        rst = 1'b0;
        set4(4'd3, 4'd5, 4'd8, 1'b0, -1);
        cycle();
        drain(int'(LAT4) + 2);

        // WIDTH=1 build: exhaustive masked half adder, back to back.
        set1(1'b0, 1'b0, 1'b0, 1'b0); cycle();
        set1(1'b0, 1'b1, 1'b1, 1'b0); cycle();
        set1(1'b1, 1'b0, 1'b1, 1'b0); cycle();
        set1(1'b1, 1'b1, 1'b0, 1'b1); cycle();
        drain(int'(LAT1) + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/masked_adder_pipe.md
# masked_adder_pipe

Parametrised, fully pipelined two-share Boolean-masked ripple-carry adder for the masked-gadget evaluation suite. Adds two WIDTH-bit operands, each supplied as two Boolean shares, and returns the masked sum and carry-out. Every nonlinear gate is a registered DOM-indep AND refreshed with fresh randomness. All outputs are registered, so the block is directly usable as a PROLEAD evaluation target. It supersedes the single-bit masked half-adder harness with multi-bit width, valid tracking, reset and full throughput.

## Interface
- WIDTH, 4, operand width in bits; legal range 1..32.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  1  operand shares valid this cycle.
- i_a0, i_a1  in  WIDTH  shares of A (A = i_a0 ^ i_a1).
- i_b0, i_b1  in  WIDTH  shares of B.
- i_rnd  in  2*WIDTH  fresh uniform randomness, new every cycle; consumed in every cycle, whether or not any stage holds valid data.
- o_valid  out  1  output shares valid.
- o_sum0, o_sum1  out  WIDTH  shares of (A+B) mod 2^WIDTH.
- o_cout0, o_cout1  out  1  shares of carry-out bit WIDTH of A+B.

## Operation
- Input stage (S_in) registers i_a*/i_b*/i_valid. Carry shares c_0 are constant 0.
- Carry stage s (s = 0..WIDTH-1) computes, sharewise:
  - p_s = a_s ^ b_s
  - g_s = DOM_AND(a_s, b_s, i_rnd[2s])
  - t_s = DOM_AND(p_s, c_s, i_rnd[2s+1])
  - c_{s+1} = g_s ^ t_s; the XOR compression happens at the input of stage s+1.
- DOM_AND, share j: registers the domain term x_j&y_j. Share 0 also registers (x_0&y_1)^r; share 1 also registers (x_1&y_0)^r. The output share is the XOR of the two registered terms.
- Stage 0 still runs its t-AND with zero carry shares and consumes i_rnd[1]. The structure stays uniform across stages.
- Operand bits not yet consumed and p_s bits already produced travel down sharewise delay lines, aligned with their carry stage.
- Output stage: o_sum_j[s] = p_s,j ^ c_s,j and o_cout_j = c_WIDTH,j, all registered.
- Linear operations never combine share 0 with share 1. Only the DOM cross-products touch both domains, and only after masking with r.
- i_valid travels down a WIDTH+2 deep valid shift register to o_valid. Data registers are not gated by valid; o_* are don't-care while o_valid=0.
- No backpressure: a new operand pair is accepted every cycle.

## Timing
- Latency: i_valid sampled in cycle n gives o_valid=1 and results in cycle n+WIDTH+2. For WIDTH=4, that is 6 cycles.
- Throughput: 1 result per cycle. Back-to-back inputs produce back-to-back outputs in order.
- Reset:
  - rst sampled high clears every data, share and valid register to 0.
  - o_valid, o_sum*, o_cout* read 0 from the cycle after rst.
  - Reset mid-flight discards all in-flight operations; no o_valid pulse results from inputs sampled before or during rst.
- Inputs with i_valid=1 in the first cycle after rst deasserts are accepted normally.
- Randomness timing: stage s uses i_rnd[2s+1:2s] on the edge that registers its DOM terms. This is the operation's cycle n+1+s.
- Wrap-around: the sum is mod 2^WIDTH; overflow is reported only through the cout shares.
- WIDTH=1: degenerates to a masked full adder with c_0=0, i.e. a masked half adder with latency 3.

## Structure
- Shared package masked_pkg holds:
  - localparam SHARES = 2;
  - a packed typedef for a two-share bit;
  - the helper function lat(WIDTH) = WIDTH+2, used by the bench.
- One sub-module, dom_and_2sh: ports clk, rst, x0, x1, y0, y1, r, and outputs z0, z1. It holds the four registered terms with synchronous reset and is instantiated 2*WIDTH times.
- The top level contains the generate loop over stages, the delay lines, the output register and the valid shift register.

## Test plan
- Reset behaviour: rst high for 2 cycles with random inputs and i_valid=1. After release, o_valid stays 0 for WIDTH+2 cycles and o_* read 0.
- Basic add, WIDTH=4: A=3, B=5 with random masks. Six cycles later o_valid=1, sum0^sum1=8, cout0^cout1=0.
- Overflow, WIDTH=4: A=15, B=1 gives sum 0, cout 1. A=15, B=15 gives sum 14, cout 1.
- Throughput: 256 back-to-back pairs covering all A,B in 0..15 with random masks and random i_rnd each cycle. Results are in order, all match the golden model, and o_valid is continuous.
- Mask independence: the same A=9, B=6 applied 8 times with different masks and randomness. The unmasked result is 15 with cout 0 every time, while the individual output shares differ.
- Mid-flight reset and WIDTH=1 build: assert rst while 3 operations are in flight, so none emerge. Then, in a WIDTH=1 build, an exhaustive 1+1 check gives sum 0, cout 1 at latency 3.
